// File: rtl/fetch_queue_if.sv
// Bundle of the fetch queue's bus signals: flush/redirect control, the I-cache
// request/response pair and the Decoder-facing head-of-queue port.
//   slave  : used by fetch_queue (consumes control and cache responses,
//            drives requests and the head entry)
//   master : used by the surrounding core/cache/decoder side
// Parameters: XLEN (data/address width), DEPTH (queue entries, sets count width).
interface fetch_queue_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            rdy;
    logic            rob_clear;
    logic [XLEN-1:0] back_pc;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            start_fetch;
    logic [XLEN-1:0] pc;
    logic            instr_ready_in;
    logic [XLEN-1:0] instr_in;
    logic [XLEN-1:0] instr_addr_in;
    logic            instr_issued;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_addr;
    logic [CW-1:0]   count;

    modport slave (
        input  rdy, rob_clear, back_pc, redirect_valid, redirect_pc,
        input  instr_ready_in, instr_in, instr_addr_in, instr_issued,
        output start_fetch, pc, instr_ready, instr, instr_addr, count
    );

    modport master (
        output rdy, rob_clear, back_pc, redirect_valid, redirect_pc,
        output instr_ready_in, instr_in, instr_addr_in, instr_issued,
        input  start_fetch, pc, instr_ready, instr, instr_addr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetcher with a DEPTH-entry FIFO between the I-cache and the Decoder.
// Requests pc from the cache while the queue has room, pushes responses whose
// address matches pc (stale ones are dropped), advances pc by PC_STEP per accept.
// rob_clear (highest priority) and redirect_valid flush the queue and steer pc.
// Ports:
//   clk  - clock, all state on posedge
//   rst  - asynchronous active-high reset
//   bus  - fetch_queue_if.slave: rdy/flush control, cache request/response,
//          Decoder head entry (instr_ready/instr/instr_addr) and occupancy count
module fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [XLEN-1:0] mem_instr_q [DEPTH];
    logic [XLEN-1:0] mem_instr_d [DEPTH];
    logic [XLEN-1:0] mem_addr_q  [DEPTH];
    logic [XLEN-1:0] mem_addr_d  [DEPTH];
    logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            start_fetch_q, start_fetch_d;
    logic [XLEN-1:0] instr_q, instr_d, instr_addr_q, instr_addr_d;

    logic pop, push;

    always_comb begin
        mem_instr_d   = mem_instr_q;
        mem_addr_d    = mem_addr_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        pc_d          = pc_q;
        start_fetch_d = start_fetch_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;

        pop  = bus.instr_issued && (count_q != '0);
        // A same-cycle pop frees a slot, so a full queue can still accept.
        push = bus.instr_ready_in && (bus.instr_addr_in == pc_q)
               && ((count_q < CW'(DEPTH)) || pop);

        if (bus.rdy) begin
            if (bus.rob_clear || bus.redirect_valid) begin
                // A redirect's same-cycle pop is subsumed by the flush.
                head_d        = '0;
                tail_d        = '0;
                count_d       = '0;
                pc_d          = bus.rob_clear ? bus.back_pc : bus.redirect_pc;
                start_fetch_d = 1'b1;
            end else begin
                if (push) begin
                    mem_instr_d[tail_q] = bus.instr_in;
                    mem_addr_d[tail_q]  = bus.instr_addr_in;
                    tail_d              = tail_q + PW'(1);
                    pc_d                = pc_q + XLEN'(PC_STEP);
                end
                if (pop) begin
                    head_d = head_q + PW'(1);
                end
                count_d       = count_q + CW'(push) - CW'(pop);
                start_fetch_d = (count_d < CW'(DEPTH));
            end

            // Head output registers track the next head entry; a push landing
            // on the next head slot is forwarded since mem_q is not yet written.
            if (count_d == '0) begin
                instr_d      = '0;
                instr_addr_d = '0;
            end else if (push && (tail_q == head_d)) begin
                instr_d      = bus.instr_in;
                instr_addr_d = bus.instr_addr_in;
            end else begin
                instr_d      = mem_instr_q[head_d];
                instr_addr_d = mem_addr_q[head_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_instr_q[i] <= '0;
                mem_addr_q[i]  <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            pc_q          <= '0;
            start_fetch_q <= 1'b0;
            instr_q       <= '0;
            instr_addr_q  <= '0;
        end else begin
            mem_instr_q   <= mem_instr_d;
            mem_addr_q    <= mem_addr_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            pc_q          <= pc_d;
            start_fetch_q <= start_fetch_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
        end
    end

    assign bus.start_fetch = start_fetch_q;
    assign bus.pc          = pc_q;
    assign bus.count       = count_q;
    assign bus.instr_ready = (count_q != '0);
    assign bus.instr       = instr_q;
    assign bus.instr_addr  = instr_addr_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4, XLEN=32, PC_STEP=4).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    fetch_queue_if #(.XLEN(32), .DEPTH(4)) bus ();

    fetch_queue #(.DEPTH(4), .XLEN(32), .PC_STEP(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.rob_clear      = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.instr_ready_in = 1'b0;
        bus.instr_issued   = 1'b0;
    endtask

    // One-cycle cache response strobe.
    task automatic respond(input logic [31:0] addr, input logic [31:0] data);
        bus.instr_ready_in = 1'b1;
        bus.instr_addr_in  = addr;
        bus.instr_in       = data;
        tick();
        bus.instr_ready_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.rdy            = 1'b0;
        bus.back_pc        = '0;
        bus.redirect_pc    = '0;
        bus.instr_in       = '0;
        bus.instr_addr_in  = '0;
        idle_inputs();

        // Reset values
        #12;
        check("rst_pc", bus.pc, 0);
        check("rst_start", bus.start_fetch, 0);
        check("rst_count", bus.count, 0);
        check("rst_ready", bus.instr_ready, 0);
        check("rst_instr", bus.instr, 0);
        check("rst_iaddr", bus.instr_addr, 0);
        rst = 1'b0;
        tick();
        check("no_rdy_start", bus.start_fetch, 0);
        bus.rdy = 1'b1;
        tick();
        check("first_rdy_start", bus.start_fetch, 1);

        // 1. Fill with 2-cycle cache latency
        for (int i = 0; i < 4; i++) begin
            check("fill_pc", bus.pc, 64'(4 * i));
            check("fill_start", bus.start_fetch, 1);
            tick();
            respond(32'(4 * i), 32'h1000 + 32'(i));
            check("fill_count", bus.count, 64'(i + 1));
            if (i == 0) begin
                check("lat_ready", bus.instr_ready, 1);
                check("lat_instr", bus.instr, 64'h1000);
            end
        end
        check("full_start", bus.start_fetch, 0);
        check("full_iaddr", bus.instr_addr, 0);
        respond(32'd16, 32'hDEAD);
        check("full_noaccept_count", bus.count, 4);
        check("full_noaccept_pc", bus.pc, 16);

        // 2. Pop from full queue, then refill
        bus.instr_issued = 1'b1;
        tick();
        bus.instr_issued = 1'b0;
        check("pop_count", bus.count, 3);
        check("pop_iaddr", bus.instr_addr, 4);
        check("pop_instr", bus.instr, 64'h1001);
        check("pop_start", bus.start_fetch, 1);
        check("pop_pc", bus.pc, 16);
        respond(32'd16, 32'h1004);
        check("refill_count", bus.count, 4);
        check("refill_pc", bus.pc, 20);
        check("refill_start", bus.start_fetch, 0);
        // push + pop while full
        bus.instr_issued = 1'b1;
        respond(32'd20, 32'h1005);
        bus.instr_issued = 1'b0;
        check("fullpp_count", bus.count, 4);
        check("fullpp_iaddr", bus.instr_addr, 8);
        check("fullpp_pc", bus.pc, 24);

        // 3. rob_clear, stale response dropped
        bus.rob_clear = 1'b1;
        bus.back_pc   = 32'h100;
        tick();
        bus.rob_clear = 1'b0;
        check("clr_count", bus.count, 0);
        check("clr_ready", bus.instr_ready, 0);
        check("clr_instr", bus.instr, 0);
        check("clr_pc", bus.pc, 64'h100);
        check("clr_start", bus.start_fetch, 1);
        respond(32'h8, 32'hBAD0);
        check("stale_count", bus.count, 0);
        check("stale_pc", bus.pc, 64'h100);
        respond(32'h100, 32'hAAAA);
        check("post_clr_count", bus.count, 1);
        check("post_clr_iaddr", bus.instr_addr, 64'h100);
        check("post_clr_instr", bus.instr, 64'hAAAA);
        check("post_clr_pc", bus.pc, 64'h104);

        // 4. redirect with same-cycle pop and response, 3 queued
        respond(32'h104, 32'hAAAB);
        respond(32'h108, 32'hAAAC);
        check("pre_redir_count", bus.count, 3);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h40;
        bus.instr_issued   = 1'b1;
        respond(32'h10C, 32'hAAAD);
        idle_inputs();
        check("redir_count", bus.count, 0);
        check("redir_pc", bus.pc, 64'h40);
        check("redir_ready", bus.instr_ready, 0);
        check("redir_start", bus.start_fetch, 1);
        bus.instr_issued = 1'b1;
        tick();
        bus.instr_issued = 1'b0;
        check("empty_pop_count", bus.count, 0);
        // rob_clear beats redirect
        bus.rob_clear      = 1'b1;
        bus.back_pc        = 32'h200;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h300;
        tick();
        idle_inputs();
        check("prio_pc", bus.pc, 64'h200);

        // 5. Push+pop at count 2 across pointer wrap
        respond(32'h200, 32'h5000);
        respond(32'h204, 32'h5001);
        check("pp_pre_count", bus.count, 2);
        for (int k = 0; k < 10; k++) begin
            bus.instr_issued = 1'b1;
            respond(32'h208 + 32'(4 * k), 32'h5000 + 32'(k + 2));
            bus.instr_issued = 1'b0;
            check("pp_count", bus.count, 2);
            check("pp_iaddr", bus.instr_addr, 64'h200 + 64'(4 * (k + 1)));
            check("pp_instr", bus.instr, 64'h5000 + 64'(k + 1));
        end
        check("pp_pc", bus.pc, 64'h230);

        // 6. rdy=0 holds state; async reset mid-response
        bus.rdy          = 1'b0;
        bus.instr_issued = 1'b1;
        bus.rob_clear    = 1'b1;
        respond(32'h230, 32'h6000);
        idle_inputs();
        check("hold_count", bus.count, 2);
        check("hold_pc", bus.pc, 64'h230);
        check("hold_iaddr", bus.instr_addr, 64'h228);
        bus.rdy = 1'b1;
        tick();
        check("hold_rdy1_pc", bus.pc, 64'h230);
        bus.rdy            = 1'b0;
        bus.instr_ready_in = 1'b1;
        bus.instr_addr_in  = 32'h230;
        #2;
        rst = 1'b1;
        #1;
        check("arst_pc", bus.pc, 0);
        check("arst_count", bus.count, 0);
        check("arst_ready", bus.instr_ready, 0);
        check("arst_instr", bus.instr, 0);
        check("arst_iaddr", bus.instr_addr, 0);
        check("arst_start", bus.start_fetch, 0);
        idle_inputs();
        tick();
        rst     = 1'b0;
        bus.rdy = 1'b1;
        tick();
        check("rerun_start", bus.start_fetch, 1);

        // pc wraps modulo 2^XLEN
        bus.rob_clear = 1'b1;
        bus.back_pc   = 32'hFFFF_FFFC;
        tick();
        bus.rob_clear = 1'b0;
        respond(32'hFFFF_FFFC, 32'h7000);
        check("wrap_pc", bus.pc, 0);
        check("wrap_iaddr", bus.instr_addr, 64'hFFFF_FFFC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
